reset_sequencer: RTL



---
 rtl/reset_sequencer_pkg.sv | 37 +++
 rtl/reset_sequencer_if.sv | 26 ++
 rtl/reset_sequencer_cnt.sv | 30 +++
 rtl/reset_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package rstseq_pkg;

  // One-hot state encoding; any illegal pattern recovers to ST_SAFE.
  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_HOLD    = 6'b000010,
    ST_RELEASE = 6'b000100,
    ST_WAIT    = 6'b001000,
    ST_S_HOLD  = 6'b010000,
    ST_S_WAIT  = 6'b100000
  } state_t;

  // Recovering into HOLD re-runs a full sequence, the only state that
  // brings every domain back to a known condition.
  localparam state_t ST_SAFE = ST_HOLD;

  // Reset vectors sized for the largest supported domain count; the
  // top slices them down to N_DOMAINS.
  localparam logic [7:0] RSTV_IDLE   = 8'h00;
  localparam logic [7:0] RSTV_ASSERT = 8'hFF;

  function automatic int clog2_f(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request/ready/reset bundle between reset generator, sequencer and domains.
// Latency: n/a (wiring only).
// Backpressure: none; ready bits are levels sampled by the sequencer.
// master: drives requests and ready bits; slave: the sequencer.
interface reset_sequencer_if #(
  parameter int N_DOMAINS = 4
);
  logic                 seqReq;
  logic [N_DOMAINS-1:0] domainRstReq;
  logic [N_DOMAINS-1:0] domainReady;
  logic [N_DOMAINS-1:0] domainRstOut;
  logic                 seqBusy;
  logic                 seqDone;
  logic                 timeoutErr;
  logic [2:0]           failDomain;

  modport master (
    output seqReq, domainRstReq, domainReady,
    input  domainRstOut, seqBusy, seqDone, timeoutErr, failDomain
  );

  modport slave (
    input  seqReq, domainRstReq, domainReady,
    output domainRstOut, seqBusy, seqDone, timeoutErr, failDomain
  );
endinterface

// File: rtl/reset_sequencer_cnt.sv
// Shared saturating cycle counter with clear and terminal-value compare.
// Latency: clear takes effect next cycle; o_term_hit is combinational on the count.
// Backpressure: none.
// Ports: i_clk, i_resetn (sync, active-low), i_clr, i_term (loaded compare value), o_term_hit.
module rstseq_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_term_hit
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      // Saturate so an unbounded wait can never wrap into a false hit.
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_term_hit = (r_cnt == i_term);

endmodule

// File: rtl/reset_sequencer.sv
// Sequences N reset domains: assert all, release in index order, wait for ready.
// Latency: HOLD + N*(GAP+1) cycles from HOLD entry to seqDone when all domains are ready.
// Backpressure: none; requests outside IDLE are dropped (seqReq always restarts).
// Ports: i_clk, i_resetn (sync, active-low), bus (slave modport: seqReq,
//   domainRstReq, domainReady in; domainRstOut, seqBusy, seqDone, timeoutErr, failDomain out).
// Build option RSTSEQ_TIMEOUT_EN: when defined, a domain that stays not-ready for
//   TIMEOUT_CYCLES is flagged and skipped; otherwise waits are unbounded.
module reset_sequencer
  import rstseq_pkg::*;
#(
  parameter int N_DOMAINS      = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  reset_sequencer_if.slave   bus
);

  localparam int IDX_W = (N_DOMAINS > 1) ? clog2_f(N_DOMAINS) : 1;

  localparam logic [N_DOMAINS-1:0] RST_ALL  = RSTV_ASSERT[N_DOMAINS-1:0];
  localparam logic [N_DOMAINS-1:0] RST_NONE = RSTV_IDLE[N_DOMAINS-1:0];

  // Terminal counts are N-1 because the counter starts at 0 on state entry.
  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_TERM  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t               r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt, w_idx_inc, w_req_idx;
  logic [N_DOMAINS-1:0] r_rst_out, w_rst_nxt;
  logic                 r_busy;
  logic                 r_done, w_done_nxt;
  logic                 r_err, w_err_nxt;
  logic [2:0]           r_fd, w_fd_nxt;
  logic                 w_cnt_clr;
  logic                 w_term_hit;
  logic [CNT_W-1:0]     w_term;
  logic                 w_rdy_sel;
  logic                 w_tmo;

  rstseq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .i_clk      (i_clk),
    .i_resetn   (i_resetn),
    .i_clr      (w_cnt_clr),
    .i_term     (w_term),
    .o_term_hit (w_term_hit)
  );

  always_comb begin
    case (r_state)
      ST_HOLD, ST_S_HOLD: w_term = HOLD_TERM;
      ST_RELEASE:         w_term = GAP_TERM;
      default:            w_term = TMO_TERM;
    endcase
  end

  // w_term selects TMO_TERM in the wait states, so a hit there is a timeout.
`ifdef RSTSEQ_TIMEOUT_EN
  assign w_tmo = w_term_hit;
`else
  assign w_tmo = 1'b0;
`endif

  assign w_idx_inc = r_idx + IDX_W'(1);
  assign w_rdy_sel = bus.domainReady[r_idx];

  // Lowest requested domain wins a single reset.
  always_comb begin
    w_req_idx = '0;
    for (int i = N_DOMAINS - 1; i >= 0; i--) begin
      if (bus.domainRstReq[i]) w_req_idx = IDX_W'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_rst_nxt   = r_rst_out;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_fd_nxt    = r_fd;
    w_cnt_clr   = 1'b0;

    if (bus.seqReq) begin
      // Full sequence from any state, including restart of itself.
      w_state_nxt = ST_HOLD;
      w_idx_nxt   = '0;
      w_rst_nxt   = RST_ALL;
      w_err_nxt   = 1'b0;
      w_fd_nxt    = 3'd0;
      w_cnt_clr   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_clr = 1'b1;
          if (|bus.domainRstReq) begin
            w_state_nxt            = ST_S_HOLD;
            w_idx_nxt              = w_req_idx;
            w_rst_nxt              = RST_NONE;
            w_rst_nxt[w_req_idx]   = 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_term_hit) begin
            w_state_nxt  = ST_RELEASE;
            w_idx_nxt    = '0;
            w_rst_nxt[0] = 1'b0;
            w_cnt_clr    = 1'b1;
          end
        end
        ST_RELEASE: begin
          if (w_term_hit) begin
            w_state_nxt = ST_WAIT;
            w_cnt_clr   = 1'b1;
          end
        end
        ST_WAIT: begin
          // Ready wins over a timeout landing in the same cycle; either way
          // the sequence moves on so one dead domain cannot stall the rest.
          if (w_rdy_sel || w_tmo) begin
            if (!w_rdy_sel) begin
              w_err_nxt = 1'b1;
              w_fd_nxt  = 3'(r_idx);
            end
            w_cnt_clr = 1'b1;
            if (r_idx == IDX_W'(N_DOMAINS - 1)) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt          = ST_RELEASE;
              w_idx_nxt            = w_idx_inc;
              w_rst_nxt[w_idx_inc] = 1'b0;
            end
          end
        end
        ST_S_HOLD: begin
          if (w_term_hit) begin
            w_state_nxt      = ST_S_WAIT;
            w_rst_nxt[r_idx] = 1'b0;
            w_cnt_clr        = 1'b1;
          end
        end
        ST_S_WAIT: begin
          if (w_rdy_sel || w_tmo) begin
            if (!w_rdy_sel) begin
              w_err_nxt = 1'b1;
              w_fd_nxt  = 3'(r_idx);
            end
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
            w_cnt_clr   = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_SAFE;
          w_idx_nxt   = '0;
          w_rst_nxt   = RST_ALL;
          w_cnt_clr   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state   <= ST_HOLD;
      r_idx     <= '0;
      r_rst_out <= RST_ALL;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_fd      <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_rst_out <= w_rst_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_fd      <= w_fd_nxt;
    end
  end

  assign bus.domainRstOut = r_rst_out;
  assign bus.seqBusy      = r_busy;
  assign bus.seqDone      = r_done;
  assign bus.timeoutErr   = r_err;
  assign bus.failDomain   = r_fd;

endmodule
